// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and FSM state type for the mux scan sequencer
package mux_scan_pkg;
  localparam int N_CH = 4;
  localparam int SEL_W = 2;
  localparam int SETTLE_MAX = 15;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts SETTLE_CYC cycles per channel, pulses tc on the last one
// ports: clk, rst_n, en (count), clr (hold at zero), tc (terminal-count pulse)
module dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int CW = $clog2(SETTLE_MAX + 1);
  logic [CW-1:0] cnt;
  assign tc = en && cnt == CW'(SETTLE_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tc) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: steps a 4:1 mux select through all channels and assembles the sampled word
// ports: clk, rst_n, start, y_in, data_ready in; sel, busy, data_out, data_valid out
// optional: MUX_SCAN_PARITY_EN adds registered parity output (XOR of data_out)
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_in,
  input  logic             data_ready,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N_CH-1:0]  data_out,
  output logic             data_valid
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic             parity
`endif
);
  if (SETTLE_CYC < 1 || SETTLE_CYC > SETTLE_MAX) begin : g_bad_settle
    $error("SETTLE_CYC out of range 1..15");
  end
  state_t state, nxt;
  logic tc, last;
  dwell_counter #(.SETTLE_CYC(SETTLE_CYC)) u_dwell (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == SCAN),
    .clr(state != SCAN),
    .tc(tc)
  );
  assign last = tc && sel == SEL_W'(N_CH - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (start ? SCAN : IDLE) :
          state == SCAN ? (last ? HOLD : SCAN) :
          (data_ready ? IDLE : HOLD);
  // sel doubles as the channel index; it wraps to 0 after channel 3, so IDLE sees 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
    end else begin
      if (tc) begin
        data_out[sel] <= y_in;
        sel <= sel + 1'b1;
      end
      data_valid <= nxt == HOLD;
    end
`ifdef MUX_SCAN_PARITY_EN
  // y_in is the bit landing in data_out[3] on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity <= 1'b0;
    else if (last) parity <= ^{y_in, data_out[N_CH-2:0]};
`endif
endmodule
